rect_fill_engine: RTL
=====================

// Module: rect_fill_engine
// PURPOSE
//  Solid-colour rectangle fill, upstream of the memory arbiter on its rectanglefill client port.
//  Accepts one rectangle command (corners + 12-bit RGB colour) and clips it to the framebuffer.
//  Issues one 32-bit write per pixel, in raster order, through the arbiter rts/rtr handshake.
//  Pulses done when the last write has transferred; the refresh path then sees the new pixels.
// PARAMETERS
//  FB_WIDTH   320   pixels per row; one pixel per 32-bit word
//  FB_HEIGHT  240   rows in framebuffer
//  FB_BASE    0     word address of pixel (0,0); 17-bit
// PORTS
//  clk         in   1   system clock (clk25 domain)
//  rst_        in   1   asynchronous active-low reset
//  cmd_rts     in   1   command valid
//  cmd_rtr     out  1   engine ready for command
//  cmd_x0      in   10  left column, inclusive
//  cmd_y0      in   10  top row, inclusive
//  cmd_x1      in   10  right column, inclusive
//  cmd_y1      in   10  bottom row, inclusive
//  cmd_color   in   12  RGB444 {r,g,b}
//  mem_addr    out  17  arbiter rectanglefill_addr
//  mem_wrdata  out  32  arbiter rectanglefill_wrdata = {20'h0, color}
//  mem_op      out  1   1 = write; constant 1 while mem_rts is high, 0 otherwise
//  mem_rts     out  1   arbiter rectanglefill_rts_in
//  mem_rtr     in   1   arbiter rectanglefill_rtr_out
//  busy        out  1   high from command accept until done
//  done        out  1   one-cycle pulse on completion
// BEHAVIOUR
//  Reset (async, rst_=0): state IDLE; cmd_rtr=0 while rst_ low, 1 first cycle after release.
//   mem_rts=0, mem_op=0, mem_addr=0, mem_wrdata=0, busy=0, done=0; all registers cleared.
//  Command accept: cmd_rts & cmd_rtr on rising edge; cmd_rtr = (state==IDLE) only.
//   Operands are captured; later changes to cmd_* are ignored.
//  FSM: IDLE -> SETUP on accept; SETUP -> WRITE if clipped rect non-empty, else DONE.
//   WRITE -> DONE on xfc of last pixel. DONE -> IDLE (done=1 this cycle only).
//  Clipping in SETUP: x1c=min(x1,FB_WIDTH-1), y1c=min(y1,FB_HEIGHT-1).
//   Empty if x0>x1c or y0>y1c (covers x0>=FB_WIDTH, y0>=FB_HEIGHT, swapped corners).
//  Address: row_base = FB_BASE + y0*FB_WIDTH, computed once in SETUP.
//   mem_addr = row_base + x (17-bit, no wrap check needed in range).
//   Row advance: row_base += FB_WIDTH, x reloads x0 (adder only, no per-pixel multiply).
//  Handshake: mem_rts high throughout WRITE; transfer (xfc) = mem_rts & mem_rtr.
//   mem_addr/wrdata held stable until xfc; after xfc the next pixel is presented the next cycle.
//   Raster order: x0..x1c within a row, rows y0..y1c; no bubbles while mem_rtr stays high.
//  Latency: accept at edge N -> SETUP in cycle N+1 -> first mem_rts in cycle N+2.
//   done is asserted the cycle after the final xfc.
//   Empty rect: done in cycle N+2, zero writes.
//  Throughput: 1 pixel/cycle with mem_rtr held high; W*H writes total.
//  busy = (state != IDLE); done and cmd_rtr are never high in the same cycle.
//  Async reset mid-fill: outputs drop immediately, remaining writes abandoned, no done pulse.
// TESTING
//  1. FB_BASE=0, rect (1,1)-(2,2), color 12'hF00, mem_rtr=1 -> 4 xfc.
//     Addresses 321,322,641,642; data 32'h00000F00; done 1 cycle after last xfc.
//  2. Same rect, mem_rtr toggling 1010.. -> addr/data held while rtr=0.
//     Exactly 4 xfc, same order as test 1.
//  3. Swapped corners (5,5)-(2,7) -> no mem_rts.
//     done at N+2; cmd_rtr high again at N+3.
//  4. Clip: (318,239)-(500,600) -> exactly 2 writes.
//     Addresses 76798,76799.
//  5. cmd_rts held high through a fill -> second command accepted only after done.
//     Check against a 1x1 rect at (0,0): addr 0, single write.
//  6. rst_ low during 3rd write of a 4x4 rect -> mem_rts, busy low immediately.
//     No done; after release a new 1x1 command completes normally.

Source files
------------

// File: rtl/rect_fill_engine_if.sv
// Bundle of the command, memory-client and status signals of the
// rectangle fill engine. The engine uses the slave view; whoever issues
// commands and plays the arbiter uses the master view.
interface rect_fill_if;
  logic        cmd_rts;
  logic        cmd_rtr;
  logic [9:0]  cmd_x0;
  logic [9:0]  cmd_y0;
  logic [9:0]  cmd_x1;
  logic [9:0]  cmd_y1;
  logic [11:0] cmd_color;
  logic [16:0] mem_addr;
  logic [31:0] mem_wrdata;
  logic        mem_op;
  logic        mem_rts;
  logic        mem_rtr;
  logic        busy;
  logic        done;

  modport slave (
    input  cmd_rts, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color, mem_rtr,
    output cmd_rtr, mem_addr, mem_wrdata, mem_op, mem_rts, busy, done
  );

  modport master (
    output cmd_rts, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color, mem_rtr,
    input  cmd_rtr, mem_addr, mem_wrdata, mem_op, mem_rts, busy, done
  );
endinterface

// File: rtl/rect_fill_engine.sv
// Solid-colour rectangle fill: captures one command, clips it to the
// framebuffer and streams one 32-bit write per pixel in raster order
// through the rts/rtr handshake. All outputs are registered.
module rect_fill_engine #(
  parameter int          FB_WIDTH  = 320,
  parameter int          FB_HEIGHT = 240,
  parameter logic [16:0] FB_BASE   = 17'd0
) (
  input  logic        clk,
  input  logic        rst_,
  rect_fill_if.slave  bus
);

  localparam logic [9:0]  X_MAX    = 10'(FB_WIDTH - 1);
  localparam logic [9:0]  Y_MAX    = 10'(FB_HEIGHT - 1);
  localparam logic [16:0] ROW_STEP = 17'(FB_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [9:0]  x0_q, y0_q, x1_q, y1_q, x0_d, y0_d, x1_d, y1_d;
  logic [9:0]  x1c_q, y1c_q, x1c_d, y1c_d;
  logic [9:0]  x_q, y_q, x_d, y_d;
  logic [11:0] color_q, color_d;
  logic [16:0] row_base_q, row_base_d;
  logic [16:0] addr_q, addr_d;
  logic [31:0] wrdata_q, wrdata_d;
  logic        cmd_rtr_q, cmd_rtr_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        mem_rts_q, mem_rts_d;
  logic        mem_op_q, mem_op_d;

  logic        accept_s, xfc_s, row_end_s, last_s, empty_s;
  logic [9:0]  x1c_s, y1c_s;
  logic [26:0] base_prod_s;
  logic [16:0] setup_base_s;

  assign accept_s     = bus.cmd_rts & cmd_rtr_q;
  assign xfc_s        = mem_rts_q & bus.mem_rtr;
  assign row_end_s    = (x_q == x1c_q);
  assign last_s       = row_end_s & (y_q == y1c_q);
  assign x1c_s        = (x1_q > X_MAX) ? X_MAX : x1_q;
  assign y1c_s        = (y1_q > Y_MAX) ? Y_MAX : y1_q;
  // Swapped corners and origins beyond the framebuffer both end up here.
  assign empty_s      = (x0_q > x1c_s) | (y0_q > y1c_s);
  // The only multiply: first row base, evaluated once per command.
  assign base_prod_s  = 27'(y0_q) * 27'(FB_WIDTH);
  assign setup_base_s = FB_BASE + base_prod_s[16:0];

  assign bus.cmd_rtr    = cmd_rtr_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.mem_rts    = mem_rts_q;
  assign bus.mem_op     = mem_op_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wrdata = wrdata_q;

  // State register.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept_s) state_d = S_SETUP; else state_d = S_IDLE;
      S_SETUP: if (empty_s)  state_d = S_DONE;  else state_d = S_WRITE;
      S_WRITE: if (xfc_s && last_s) state_d = S_DONE; else state_d = S_WRITE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the upcoming state so every output is a flop.
  always_comb begin
    cmd_rtr_d = (state_d == S_IDLE);
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
    mem_rts_d = (state_d == S_WRITE);
    mem_op_d  = (state_d == S_WRITE);
  end

  // Datapath: operand capture, clipping, raster walk with adder-only stepping.
  always_comb begin
    x0_d       = x0_q;
    y0_d       = y0_q;
    x1_d       = x1_q;
    y1_d       = y1_q;
    color_d    = color_q;
    x1c_d      = x1c_q;
    y1c_d      = y1c_q;
    x_d        = x_q;
    y_d        = y_q;
    row_base_d = row_base_q;
    addr_d     = addr_q;
    wrdata_d   = wrdata_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          x0_d    = bus.cmd_x0;
          y0_d    = bus.cmd_y0;
          x1_d    = bus.cmd_x1;
          y1_d    = bus.cmd_y1;
          color_d = bus.cmd_color;
        end else begin
          color_d = color_q;
        end
      end
      S_SETUP: begin
        x1c_d      = x1c_s;
        y1c_d      = y1c_s;
        x_d        = x0_q;
        y_d        = y0_q;
        row_base_d = setup_base_s;
        addr_d     = setup_base_s + 17'(x0_q);
        wrdata_d   = {20'h0_0000, color_q};
      end
      S_WRITE: begin
        if (xfc_s && !last_s) begin
          if (row_end_s) begin
            x_d        = x0_q;
            y_d        = y_q + 10'd1;
            row_base_d = row_base_q + ROW_STEP;
            addr_d     = row_base_q + ROW_STEP + 17'(x0_q);
          end else begin
            x_d    = x_q + 10'd1;
            addr_d = addr_q + 17'd1;
          end
        end else begin
          addr_d = addr_q;
        end
      end
      S_DONE:  addr_d = addr_q;
      default: addr_d = addr_q;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      x0_q       <= 10'd0;
      y0_q       <= 10'd0;
      x1_q       <= 10'd0;
      y1_q       <= 10'd0;
      color_q    <= 12'd0;
      x1c_q      <= 10'd0;
      y1c_q      <= 10'd0;
      x_q        <= 10'd0;
      y_q        <= 10'd0;
      row_base_q <= 17'd0;
      addr_q     <= 17'd0;
      wrdata_q   <= 32'd0;
      cmd_rtr_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mem_rts_q  <= 1'b0;
      mem_op_q   <= 1'b0;
    end else begin
      x0_q       <= x0_d;
      y0_q       <= y0_d;
      x1_q       <= x1_d;
      y1_q       <= y1_d;
      color_q    <= color_d;
      x1c_q      <= x1c_d;
      y1c_q      <= y1c_d;
      x_q        <= x_d;
      y_q        <= y_d;
      row_base_q <= row_base_d;
      addr_q     <= addr_d;
      wrdata_q   <= wrdata_d;
      cmd_rtr_q  <= cmd_rtr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      mem_rts_q  <= mem_rts_d;
      mem_op_q   <= mem_op_d;
    end
  end

endmodule
